// File: rtl/mode_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mode_seq_pkg
// Description : Panel state codes and display-format codes shared by the
//               mode sequencer, format latch, display mux and counters.
// Revision    : 1.0 - initial release
// ============================================================================
package mode_seq_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'b000,
    ST_SET_HOUR   = 3'b001,
    ST_SET_MIN    = 3'b010,
    ST_ALM_HOUR   = 3'b011,
    ST_ALM_MIN    = 3'b100,
    ST_ALM_ARM    = 3'b101,
    ST_SET_FORMAT = 3'b110,
    ST_UNUSED     = 3'b111
  } state_t;

  localparam logic FMT_24H = 1'b0;
  localparam logic FMT_12H = 1'b1;

  // Mode-button successor; the last real state and the unused code both wrap to RUN
  function automatic state_t next_state(input state_t s);
    if (s == ST_SET_FORMAT || s == ST_UNUSED) return ST_RUN;
    return state_t'(s + 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mode_sequencer_if
// Description : Button, tick and panel-output bundle of the mode sequencer.
//               master = panel/stimulus side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mode_sequencer_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] state;
  logic       modeDisp;
  logic       alarm_en;
  logic       inc_pulse;
  logic       dec_pulse;

  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down,
    input  state, modeDisp, alarm_en, inc_pulse, dec_pulse
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down,
    output state, modeDisp, alarm_en, inc_pulse, dec_pulse
  );
endinterface
`default_nettype wire

// File: rtl/mode_sequencer_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge
// Description : Previous-level register and rising-edge detect for one
//               debounced, clk-synchronous button level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic level,
  output logic      rise
);

  logic r_prev;

  // Remember last cycle's level; cleared on reset so stale history is dropped
  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= level;
  end

  assign rise = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mode_sequencer
// Description : Alarm-clock front-panel controller. Converts button levels
//               into the panel state code, 12/24 h selection, alarm arm flag
//               and inc/dec strobes; returns to RUN after TIMEOUT_S seconds
//               of inactivity (TIMEOUT_S valid range 1..63).
//               Optional macro MODE_SEQ_AUTO_REPEAT_EN: held up/down in the
//               field-set states repeats strobes every REPEAT_TICKS seconds.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int TIMEOUT_S = 10
`ifdef MODE_SEQ_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_TICKS = 4
`endif
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mode_sequencer_if.slave  bus
);

  localparam logic [5:0] c_TMO_LAST = 6'(TIMEOUT_S - 1);

  state_t     r_state;
  logic       r_mode_disp;
  logic       r_alarm_en;
  logic       r_inc;
  logic       r_dec;
  logic [5:0] r_tmo_cnt;

  logic w_mode_e;
  logic w_up_e;
  logic w_down_e;
  logic w_field;
  logic w_hold;
  logic w_rpt_fire;

  btn_edge u_edge_mode (.clk(clk), .reset(reset), .level(bus.btn_mode), .rise(w_mode_e));
  btn_edge u_edge_up   (.clk(clk), .reset(reset), .level(bus.btn_up),   .rise(w_up_e));
  btn_edge u_edge_down (.clk(clk), .reset(reset), .level(bus.btn_down), .rise(w_down_e));

  assign w_field = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) ||
                   (r_state == ST_ALM_HOUR) || (r_state == ST_ALM_MIN);

`ifdef MODE_SEQ_AUTO_REPEAT_EN
  localparam logic [2:0] c_RPT_LAST = 3'(REPEAT_TICKS - 1);

  logic [2:0] r_rpt_cnt;

  // A lone up or down held past its edge (no edge anywhere this cycle) counts as holding
  assign w_hold     = w_field & (bus.btn_up ^ bus.btn_down) & ~(w_mode_e | w_up_e | w_down_e);
  assign w_rpt_fire = w_hold & bus.tick_1hz & (r_rpt_cnt == c_RPT_LAST);

  // Repeat interval counter: runs on ticks only while holding, cleared otherwise
  always_ff @(posedge clk) begin
    if (reset || !w_hold)  r_rpt_cnt <= 3'd0;
    else if (bus.tick_1hz) r_rpt_cnt <= (r_rpt_cnt == c_RPT_LAST) ? 3'd0 : r_rpt_cnt + 3'd1;
  end
`else
  assign w_hold     = 1'b0;
  assign w_rpt_fire = 1'b0;
`endif

  // Panel FSM: state advance, field actions, persistent flags and inactivity timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_mode_disp <= FMT_24H;
      r_alarm_en  <= 1'b0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_tmo_cnt   <= 6'd0;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      if (r_state == ST_UNUSED) begin
        r_state   <= ST_RUN;
        r_tmo_cnt <= 6'd0;
      end else if (w_mode_e) begin
        // Mode wins over same-cycle up/down; those edges are dropped
        r_state   <= next_state(r_state);
        r_tmo_cnt <= 6'd0;
      end else if (w_up_e || w_down_e) begin
        r_tmo_cnt <= 6'd0;
        // Simultaneous up and down cancel each other
        if (w_up_e ^ w_down_e) begin
          if (w_field) begin
            r_inc <= w_up_e;
            r_dec <= w_down_e;
          end else if (r_state == ST_ALM_ARM) begin
            r_alarm_en <= ~r_alarm_en;
          end else if (r_state == ST_SET_FORMAT) begin
            r_mode_disp <= ~r_mode_disp;
          end
        end
      end else if (w_hold) begin
        r_tmo_cnt <= 6'd0;
        r_inc     <= w_rpt_fire & bus.btn_up;
        r_dec     <= w_rpt_fire & bus.btn_down;
      end else if (r_state == ST_RUN) begin
        r_tmo_cnt <= 6'd0;
      end else if (bus.tick_1hz) begin
        if (r_tmo_cnt == c_TMO_LAST) begin
          r_state   <= ST_RUN;
          r_tmo_cnt <= 6'd0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 6'd1;
        end
      end
    end
  end

  assign bus.state     = r_state;
  assign bus.modeDisp  = r_mode_disp;
  assign bus.alarm_en  = r_alarm_en;
  assign bus.inc_pulse = r_inc;
  assign bus.dec_pulse = r_dec;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_sequencer
// Description : Directed self-checking bench for mode_sequencer
//               (TIMEOUT_S = 10, auto-repeat macro undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mode_sequencer_if bus ();

  mode_sequencer #(.TIMEOUT_S(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    step();
    bus.btn_mode = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.state !== 3'b000) begin errors++; $display("FAIL reset_state actual=%b required=000", bus.state); end
    checks++;
    if ({bus.modeDisp, bus.alarm_en, bus.inc_pulse, bus.dec_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags actual=%b required=0000",
               {bus.modeDisp, bus.alarm_en, bus.inc_pulse, bus.dec_pulse});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mode_cycle();
    logic [2:0] exp_seq [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000};
    for (int i = 0; i < 7; i++) begin
      bus.btn_mode = 1'b1;
      step();
      checks++;
      if (bus.state !== exp_seq[i] || bus.inc_pulse !== 1'b0 || bus.dec_pulse !== 1'b0) begin
        errors++;
        $display("FAIL mode_cycle[%0d] actual state=%b inc=%b dec=%b required state=%b inc=0 dec=0",
                 i, bus.state, bus.inc_pulse, bus.dec_pulse, exp_seq[i]);
      end
      bus.btn_mode = 1'b0;
      step();
    end
  endtask

  task automatic test_inc_dec();
    int extra;
    press_mode();
    press_mode();
    checks++;
    if (bus.state !== 3'b010) begin errors++; $display("FAIL reach_set_min actual=%b required=010", bus.state); end
    bus.btn_up = 1'b1;
    step();
    checks++;
    if (bus.inc_pulse !== 1'b1 || bus.dec_pulse !== 1'b0) begin
      errors++; $display("FAIL up_edge actual inc=%b dec=%b required inc=1 dec=0", bus.inc_pulse, bus.dec_pulse);
    end
    step();
    checks++;
    if (bus.inc_pulse !== 1'b0) begin errors++; $display("FAIL up_one_cycle actual inc=%b required=0", bus.inc_pulse); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.inc_pulse === 1'b1 || bus.dec_pulse === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL up_hold_no_repeat actual pulses=%0d required=0", extra); end
    bus.btn_up = 1'b0;
    step();
    bus.btn_down = 1'b1;
    step();
    checks++;
    if (bus.dec_pulse !== 1'b1 || bus.inc_pulse !== 1'b0) begin
      errors++; $display("FAIL down_edge actual inc=%b dec=%b required inc=0 dec=1", bus.inc_pulse, bus.dec_pulse);
    end
    bus.btn_down = 1'b0;
    step();
  endtask

  task automatic test_format_alarm();
    press_mode();
    press_mode();
    press_mode();
    bus.btn_up = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'b101 || bus.alarm_en !== 1'b1 || bus.inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL alarm_toggle actual state=%b alarm_en=%b inc=%b required state=101 alarm_en=1 inc=0",
               bus.state, bus.alarm_en, bus.inc_pulse);
    end
    bus.btn_up = 1'b0;
    step();
    press_mode();
    bus.btn_up = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'b110 || bus.modeDisp !== 1'b1 || bus.inc_pulse !== 1'b0) begin
      errors++;
      $display("FAIL fmt_up actual state=%b modeDisp=%b inc=%b required state=110 modeDisp=1 inc=0",
               bus.state, bus.modeDisp, bus.inc_pulse);
    end
    bus.btn_up = 1'b0;
    step();
    bus.btn_down = 1'b1;
    step();
    checks++;
    if (bus.modeDisp !== 1'b0 || bus.dec_pulse !== 1'b0) begin
      errors++; $display("FAIL fmt_down actual modeDisp=%b dec=%b required modeDisp=0 dec=0", bus.modeDisp, bus.dec_pulse);
    end
    bus.btn_down = 1'b0;
    step();
    press_mode();
    checks++;
    if (bus.state !== 3'b000 || bus.alarm_en !== 1'b1 || bus.modeDisp !== 1'b0) begin
      errors++;
      $display("FAIL persist actual state=%b alarm_en=%b modeDisp=%b required state=000 alarm_en=1 modeDisp=0",
               bus.state, bus.alarm_en, bus.modeDisp);
    end
  endtask

  task automatic test_priority();
    press_mode();
    bus.btn_mode = 1'b1;
    bus.btn_up   = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'b010 || bus.inc_pulse !== 1'b0) begin
      errors++; $display("FAIL mode_beats_up actual state=%b inc=%b required state=010 inc=0", bus.state, bus.inc_pulse);
    end
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    step();
    for (int i = 0; i < 6; i++) press_mode();
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'b001 || bus.inc_pulse !== 1'b0 || bus.dec_pulse !== 1'b0) begin
      errors++;
      $display("FAIL up_down_cancel actual state=%b inc=%b dec=%b required state=001 inc=0 dec=0",
               bus.state, bus.inc_pulse, bus.dec_pulse);
    end
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    press_mode();
    press_mode();
    ticks(9);
    checks++;
    if (bus.state !== 3'b011) begin errors++; $display("FAIL tmo_before actual=%b required=011", bus.state); end
    bus.tick_1hz = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'b000) begin errors++; $display("FAIL tmo_10th_tick actual=%b required=000", bus.state); end
    bus.tick_1hz = 1'b0;
    step();
    press_mode();
    press_mode();
    press_mode();
    ticks(8);
    // Ninth tick coincides with an up press: counter restarts
    bus.tick_1hz = 1'b1;
    bus.btn_up   = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    bus.btn_up   = 1'b0;
    step();
    ticks(1);
    checks++;
    if (bus.state !== 3'b011) begin errors++; $display("FAIL tmo_press_tick9 actual=%b required=011", bus.state); end
    ticks(8);
    // Final tick together with a button edge: edge wins
    bus.tick_1hz = 1'b1;
    bus.btn_down = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    bus.btn_down = 1'b0;
    step();
    checks++;
    if (bus.state !== 3'b011) begin errors++; $display("FAIL tmo_edge_wins actual=%b required=011", bus.state); end
    ticks(9);
    checks++;
    if (bus.state !== 3'b011) begin errors++; $display("FAIL tmo_restart_9 actual=%b required=011", bus.state); end
    ticks(1);
    checks++;
    if (bus.state !== 3'b000) begin errors++; $display("FAIL tmo_restart_10 actual=%b required=000", bus.state); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) press_mode();
    bus.btn_up = 1'b1;
    step();
    bus.btn_up = 1'b0;
    step();
    checks++;
    if (bus.state !== 3'b110 || bus.modeDisp !== 1'b1 || bus.alarm_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset actual state=%b modeDisp=%b alarm_en=%b required state=110 modeDisp=1 alarm_en=1",
               bus.state, bus.modeDisp, bus.alarm_en);
    end
    reset        = 1'b1;
    bus.btn_mode = 1'b1;
    step();
    checks++;
    if (bus.state !== 3'b000 || bus.modeDisp !== 1'b0 || bus.alarm_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset actual state=%b modeDisp=%b alarm_en=%b required state=000 modeDisp=0 alarm_en=0",
               bus.state, bus.modeDisp, bus.alarm_en);
    end
    bus.btn_mode = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.state !== 3'b000) begin errors++; $display("FAIL post_reset actual=%b required=000", bus.state); end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    test_reset();
    test_mode_cycle();
    test_inc_dec();
    test_format_alarm();
    test_priority();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Front-panel controller for the alarm clock.
- Turns debounced push-button levels into the 3-bit `state` code and the `modeDisp` format selection consumed by the display-format latch.
- Emits one-cycle increment/decrement strobes to the time and alarm counters.
- Returns to run mode automatically after a period with no button activity.

Parameters:
- TIMEOUT_S, 10: seconds of inactivity in any non-RUN state before forced return to RUN; valid range 1..63.
- REPEAT_TICKS, 4: tick_1hz periods between auto-repeat strobes; used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle strobe, once per second
- btn_mode  in  1  debounced, clk-synchronous level; advances state
- btn_up  in  1  debounced, clk-synchronous level
- btn_down  in  1  debounced, clk-synchronous level
- state  out  3  current panel state code
- modeDisp  out  1  format selection: 0 = 24 h, 1 = 12 h
- alarm_en  out  1  alarm armed flag
- inc_pulse  out  1  one-cycle increment strobe for the field selected by state
- dec_pulse  out  1  one-cycle decrement strobe for the field selected by state

Behaviour:
- Clocking and reset
  - All outputs are registered.
  - Reset values: state=3'b000, modeDisp=0, alarm_en=0, inc_pulse=0, dec_pulse=0; timeout counter and button history registers=0.
  - Reset mid-operation discards any pending edge and aborts any timeout in progress.
- Edge detection
  - Each button has a previous-level register; edge = level & ~prev.
  - A button held high gives exactly one edge.
  - Outputs update on the same clk edge at which the edge is detected: latency 1 cycle from the input rising.
- State codes
  - 000 RUN, 001 SET_HOUR, 010 SET_MIN, 011 ALM_HOUR, 100 ALM_MIN, 101 ALM_ARM, 110 SET_FORMAT.
  - 111 is unused; if reached, it goes to 000 on the next clk.
- State advance
  - btn_mode edge: 000→001→010→011→100→101→110→000 (wraps).
- Field actions (only when no btn_mode edge in the same cycle)
  - RUN: up and down are ignored; pulses stay 0.
  - 001–100: up edge → inc_pulse=1 for one cycle; down edge → dec_pulse=1 for one cycle.
  - 101: up or down edge toggles alarm_en; no pulses.
  - 110: up or down edge toggles modeDisp; no pulses.
- Priority and simultaneous events
  - btn_mode edge beats up/down edges in the same cycle; the up/down edges are dropped.
  - up and down edges in the same cycle cancel: no pulse, no toggle.
- Persistence
  - modeDisp and alarm_en hold their values in every state, including after timeout.
- Timeout
  - The 6-bit counter clears on any button edge and on entry to RUN.
  - In non-RUN states it increments on tick_1hz.
  - When a tick arrives with counter==TIMEOUT_S-1: state←000 and counter←0.
  - If a button edge and the final tick land in the same cycle, the button edge wins and the counter clears.
- inc_pulse and dec_pulse are never high together.

Optional Feature:
- Macro: MODE_SEQ_AUTO_REPEAT_EN.
- Defined:
  - In states 001–100, holding btn_up (or btn_down) alone past the initial edge repeats inc_pulse (or dec_pulse).
  - One repeat pulse every REPEAT_TICKS tick_1hz strobes, using a 3-bit repeat counter cleared on the edge and on release.
  - Holding suppresses the timeout.
- Undefined: single edge-triggered strobes only; no repeat counter is synthesized.

Decomposition:
- Package mode_seq_pkg holds the 3-bit state code constants (ST_RUN..ST_SET_FORMAT) and FMT_24H=0 / FMT_12H=1.
- These are shared with the format latch, display mux and counters.
- One sub-module, btn_edge: per-button level register plus rising-edge output, instantiated three times.

Test Plan:
- Reset, then 7 btn_mode presses → state sequence 001,010,011,100,101,110,000; all pulses 0 throughout.
- In 010, up press → inc_pulse high exactly 1 cycle; hold up 20 cycles → no further pulse (macro undefined).
- In 110, press up then down → modeDisp 0→1→0; inc_pulse and dec_pulse stay 0.
- btn_mode and btn_up rise in the same cycle while in 001 → state=010 with no inc_pulse; up+down together in 001 → no pulse.
- In 011 with TIMEOUT_S=10, no buttons, 10 ticks → state=000 on the 10th tick; with a press at tick 9 → still 011 after tick 10.
- Assert reset mid-SET_FORMAT with modeDisp=1 → state=000, modeDisp=0, alarm_en=0 on the next clk.
